logo_overlay: RTL and testbench

- Display-path stage that drives the logo ROM lookup and consumes its colour output.
- Takes raw VGA scan coordinates and timing, and converts them into logo-relative x/y for the logo image block.
- Animates the logo origin so the logo slides up from off-screen and then holds.
- Merges the returned 12-bit logo colour over the background colour, with sync signals delay-matched to the ROM latency.

---
 rtl/logo_overlay_pkg.sv | 40 ++++
 rtl/logo_overlay_if.sv | 44 ++++
 rtl/logo_overlay_origin_fsm.sv | 66 ++++++
 rtl/logo_overlay.sv | 172 +++++++++++++++++
 tb/tb_logo_overlay.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/logo_overlay_pkg.sv
// Shared constants and types for the logo overlay display stage.
// The logo dimensions live here so the logo image block can use the same
// row stride (LOGO_W) as the address generator.
// Optional feature macro: LOGO_TRANSPARENT_EN (colour-keyed transparency).
package logo_overlay_pkg;

    // Visible screen area (640x480 VGA).
    localparam int H_VISIBLE = 640;
    localparam int V_VISIBLE = 480;

    // Logo image geometry; LOGO_W is also the ROM row stride.
    localparam int LOGO_W = 250;
    localparam int LOGO_H = 100;

    // Horizontal placement: centred, (640-250)/2.
    localparam int LOGO_X0 = 195;

    // Vertical animation: start fully off-screen and slide up to TARGET_Y.
    localparam int START_Y  = 480;
    localparam int TARGET_Y = 100;
    localparam int STEP     = 4;

    // 12-bit RGB colour (4 bits per channel).
    typedef logic [11:0] color_t;

    // Colour treated as transparent when LOGO_TRANSPARENT_EN is defined.
    localparam color_t KEY_CLR = 12'h0F0;

    // Origin animation states.
    typedef enum logic {
        ST_SLIDE = 1'b0,
        ST_HOLD  = 1'b1
    } origin_state_t;

    // Zero-extend a scan coordinate so range compares cannot wrap.
    function automatic logic [10:0] ext11(input logic [9:0] v);
        return {1'b0, v};
    endfunction

endpackage

// File: rtl/logo_overlay_if.sv
// Signal bundle between the scan-timing source / logo ROM and the overlay.
// Transfer semantics: there is no valid/ready handshake. Exactly one pixel
// is presented per clock and accepted unconditionally; rom_clr must carry
// the ROM data for the logo_x/logo_y presented one cycle earlier.
interface logo_overlay_if;
    import logo_overlay_pkg::*;

    logic [9:0]    pix_x;
    logic [8:0]    pix_y;
    logic          video_on_in;
    logic          hsync_in;
    logic          vsync_in;
    color_t        bg_clr;
    logic          restart;
    color_t        rom_clr;

    logic [9:0]    logo_x;
    logic [8:0]    logo_y;
    color_t        rgb;
    logic          hsync;
    logic          vsync;
    logic          settled;

    // Observation of the origin animation (current origin and FSM state).
    logic [8:0]    dbg_org_y;
    origin_state_t dbg_state;

    // Timing source / ROM side.
    modport master (
        output pix_x, pix_y, video_on_in, hsync_in, vsync_in, bg_clr,
               restart, rom_clr,
        input  logo_x, logo_y, rgb, hsync, vsync, settled,
               dbg_org_y, dbg_state
    );

    // Overlay stage side.
    modport slave (
        input  pix_x, pix_y, video_on_in, hsync_in, vsync_in, bg_clr,
               restart, rom_clr,
        output logo_x, logo_y, rgb, hsync, vsync, settled,
               dbg_org_y, dbg_state
    );

endinterface

// File: rtl/logo_overlay_origin_fsm.sv
// Vertical origin animation for the logo: detects the once-per-frame tick
// in vertical blanking, slides the origin up by STEP per frame until it
// reaches TARGET_Y, then holds. A restart pulse replays the slide-in.
module logo_origin_fsm
    import logo_overlay_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic [9:0]    pix_x_i,
    input  logic [8:0]    pix_y_i,
    input  logic          restart_i,
    output logic [8:0]    org_y_o,
    output logic          settled_o,
    output origin_state_t state_o
);

    // Tick sits at the start of the first blanking line, so the origin
    // never moves while a visible frame is being drawn.
    logic tick;
    assign tick = (pix_x_i == 10'd0) && (pix_y_i == 9'(V_VISIBLE));

    origin_state_t state_q;
    logic [8:0]    org_y_q;
    logic          settled_q;

    // Origin state machine: reset > restart > frame tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_SLIDE;
            org_y_q   <= 9'(START_Y);
            settled_q <= 1'b0;
        end else if (restart_i) begin
            state_q   <= ST_SLIDE;
            org_y_q   <= 9'(START_Y);
            settled_q <= 1'b0;
        end else begin
            case (state_q)
                ST_SLIDE: begin
                    if (tick) begin
                        if (org_y_q <= 9'(TARGET_Y + STEP)) begin
                            // Clamp exactly onto the target instead of overshooting.
                            org_y_q   <= 9'(TARGET_Y);
                            state_q   <= ST_HOLD;
                            settled_q <= 1'b1;
                        end else begin
                            org_y_q <= org_y_q - 9'(STEP);
                        end
                    end
                end
                ST_HOLD: begin
                    settled_q <= 1'b1;
                end
                default: begin
                    state_q   <= ST_SLIDE;
                    org_y_q   <= 9'(START_Y);
                    settled_q <= 1'b0;
                end
            endcase
        end
    end

    assign org_y_o   = org_y_q;
    assign settled_o = settled_q;
    assign state_o   = state_q;

endmodule

// File: rtl/logo_overlay.sv
// Logo overlay display stage. Converts scan coordinates into logo-relative
// ROM addresses, merges the returned logo colour over the background and
// delays the syncs to match. Total latency from pix_x/pix_y to rgb is
// 3 cycles: S1 (address + side-band), S2 (ROM read in flight), output.
// Optional feature macro: LOGO_TRANSPARENT_EN -- when defined, logo pixels
// equal to KEY_CLR show the background instead.
module logo_overlay
    import logo_overlay_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    logo_overlay_if.slave bus
);

    // ------------------------------------------------------------------
    // Origin animation
    // ------------------------------------------------------------------
    logic [8:0]    org_y;
    logic          settled;
    origin_state_t org_state;

    logo_origin_fsm u_origin (
        .clk       (clk),
        .rst       (rst),
        .pix_x_i   (bus.pix_x),
        .pix_y_i   (bus.pix_y),
        .restart_i (bus.restart),
        .org_y_o   (org_y),
        .settled_o (settled),
        .state_o   (org_state)
    );

    // ------------------------------------------------------------------
    // Logo window detection and address generation
    // ------------------------------------------------------------------
    // 11-bit compares: org_y + LOGO_H can exceed 511 while sliding in.
    logic [10:0] x_ext;
    logic [10:0] y_ext;
    logic [10:0] org_ext;
    logic [10:0] dx;
    logic [10:0] dy;
    logic        in_logo;
    logic [9:0]  logo_x_d;
    logic [8:0]  logo_y_d;

    assign x_ext   = ext11(bus.pix_x);
    assign y_ext   = ext11({1'b0, bus.pix_y});
    assign org_ext = ext11({1'b0, org_y});
    assign dx      = x_ext - 11'(LOGO_X0);
    assign dy      = y_ext - org_ext;

    // Window test and logo-relative address; address parks at 0 outside.
    always_comb begin
        in_logo  = bus.video_on_in
                 && (x_ext >= 11'(LOGO_X0))
                 && (x_ext <  11'(LOGO_X0 + LOGO_W))
                 && (y_ext >= org_ext)
                 && (y_ext <  org_ext + 11'(LOGO_H));
        logo_x_d = '0;
        logo_y_d = '0;
        if (in_logo) begin
            logo_x_d = dx[9:0];
            logo_y_d = dy[8:0];
        end
    end

    // ------------------------------------------------------------------
    // S1: ROM address plus side-band for the same pixel
    // ------------------------------------------------------------------
    logic [9:0] logo_x_q;
    logic [8:0] logo_y_q;
    logic       in_logo_s1_q;
    logic       von_s1_q;
    logic       hs_s1_q;
    logic       vs_s1_q;
    color_t     bg_s1_q;

    // Register the ROM address and everything that must travel with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            logo_x_q     <= '0;
            logo_y_q     <= '0;
            in_logo_s1_q <= 1'b0;
            von_s1_q     <= 1'b0;
            hs_s1_q      <= 1'b1;
            vs_s1_q      <= 1'b1;
            bg_s1_q      <= '0;
        end else begin
            logo_x_q     <= logo_x_d;
            logo_y_q     <= logo_y_d;
            in_logo_s1_q <= in_logo;
            von_s1_q     <= bus.video_on_in;
            hs_s1_q      <= bus.hsync_in;
            vs_s1_q      <= bus.vsync_in;
            bg_s1_q      <= bus.bg_clr;
        end
    end

    // ------------------------------------------------------------------
    // S2: side-band waits here while the ROM returns rom_clr
    // ------------------------------------------------------------------
    logic   in_logo_s2_q;
    logic   von_s2_q;
    logic   hs_s2_q;
    logic   vs_s2_q;
    color_t bg_s2_q;

    // Second delay stage to line up with the one-cycle ROM read.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_logo_s2_q <= 1'b0;
            von_s2_q     <= 1'b0;
            hs_s2_q      <= 1'b1;
            vs_s2_q      <= 1'b1;
            bg_s2_q      <= '0;
        end else begin
            in_logo_s2_q <= in_logo_s1_q;
            von_s2_q     <= von_s1_q;
            hs_s2_q      <= hs_s1_q;
            vs_s2_q      <= vs_s1_q;
            bg_s2_q      <= bg_s1_q;
        end
    end

    // ------------------------------------------------------------------
    // Colour select and output registers
    // ------------------------------------------------------------------
    color_t rgb_d;

    // Blank outside the visible area, logo over background inside it.
    always_comb begin
        rgb_d = '0;
        if (von_s2_q) begin
            if (in_logo_s2_q) begin
`ifdef LOGO_TRANSPARENT_EN
                rgb_d = (bus.rom_clr == KEY_CLR) ? bg_s2_q : bus.rom_clr;
`else
                rgb_d = bus.rom_clr;
`endif
            end else begin
                rgb_d = bg_s2_q;
            end
        end
    end

    color_t rgb_q;
    logic   hs_q;
    logic   vs_q;

    // Final pixel colour and syncs, three cycles after the scan position.
    always_ff @(posedge clk) begin
        if (rst) begin
            rgb_q <= '0;
            hs_q  <= 1'b1;
            vs_q  <= 1'b1;
        end else begin
            rgb_q <= rgb_d;
            hs_q  <= hs_s2_q;
            vs_q  <= vs_s2_q;
        end
    end

    assign bus.logo_x    = logo_x_q;
    assign bus.logo_y    = logo_y_q;
    assign bus.rgb       = rgb_q;
    assign bus.hsync     = hs_q;
    assign bus.vsync     = vs_q;
    assign bus.settled   = settled;
    assign bus.dbg_org_y = org_y;
    assign bus.dbg_state = org_state;

endmodule

// File: tb/tb_logo_overlay.sv
// Bench for logo_overlay: randomized scan pixels plus directed steps,
// checked against a frame-count based model of the logo position.
module tb_logo_overlay;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logo_overlay_if bus ();

    logo_overlay dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- logo ROM model ----------------
    bit          rom_const_en  = 1'b0;
    logic [11:0] rom_const_val = 12'h000;

    function automatic logic [11:0] rom_fn(input int x, input int y);
        int v;
        v = (x * 31 + y * 17 + 12'h3C1) ^ (y << 5);
        return v[11:0];
    endfunction

    always @(posedge clk)
        bus.rom_clr <= rom_const_en ? rom_const_val : rom_fn(int'(bus.logo_x), int'(bus.logo_y));

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    int n_frames = 0;              // ticks seen since reset/restart
    logic [13:0] exp_q[$];         // {rgb, hsync, vsync} in output order

    function automatic int model_org(input int n);
        if (n >= 95) return 100;
        return 480 - 4 * n;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, expv, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step(input int x, input int y, input bit hs, input bit vs,
                        input logic [11:0] bg, input bit rs);
        int org, lx, ly;
        bit von, inl;
        logic [11:0] rom, rgb_e;
        org = model_org(n_frames);
        von = (x < 640) && (y < 480);
        inl = von && (x >= 195) && (x < 445) && (y >= org) && (y < org + 100);
        lx  = inl ? x - 195 : 0;
        ly  = inl ? y - org : 0;
        rom = rom_const_en ? rom_const_val : rom_fn(lx, ly);
        if (!von)     rgb_e = 12'h000;
        else if (inl) rgb_e = rom;
        else          rgb_e = bg;
`ifdef LOGO_TRANSPARENT_EN
        if (von && inl && rom == 12'h0F0) rgb_e = bg;
`endif
        bus.pix_x       = 10'(x);
        bus.pix_y       = 9'(y);
        bus.video_on_in = von;
        bus.hsync_in    = hs;
        bus.vsync_in    = vs;
        bus.bg_clr      = bg;
        bus.restart     = rs;
        exp_q.push_back({rgb_e, hs, vs});
        @(posedge clk);
        #1;
        if (rs) n_frames = 0;
        else if (x == 0 && y == 480 && n_frames < 200) n_frames++;
        begin
            logic [13:0] e;
            e = exp_q.pop_front();
            chk("logo_x", 32'(bus.logo_x), 32'(lx));
            chk("logo_y", 32'(bus.logo_y), 32'(ly));
            chk("rgb", 32'(bus.rgb), 32'(e[13:2]));
            chk("hsync", 32'(bus.hsync), 32'(e[1]));
            chk("vsync", 32'(bus.vsync), 32'(e[0]));
        end
        chk("settled", 32'(bus.settled), 32'(n_frames >= 95));
        chk("org_y", 32'(bus.dbg_org_y), 32'(model_org(n_frames)));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.pix_x       = 10'($urandom_range(0, 639));
            bus.pix_y       = 9'($urandom_range(0, 479));
            bus.video_on_in = 1'b1;
            bus.hsync_in    = 1'($urandom_range(0, 1));
            bus.vsync_in    = 1'($urandom_range(0, 1));
            bus.bg_clr      = 12'($urandom);
            bus.restart     = 1'b0;
            @(posedge clk);
            #1;
            chk("rst_rgb", 32'(bus.rgb), 32'h0);
            chk("rst_hsync", 32'(bus.hsync), 32'h1);
            chk("rst_vsync", 32'(bus.vsync), 32'h1);
            chk("rst_logo_x", 32'(bus.logo_x), 32'h0);
            chk("rst_logo_y", 32'(bus.logo_y), 32'h0);
            chk("rst_settled", 32'(bus.settled), 32'h0);
            chk("rst_org_y", 32'(bus.dbg_org_y), 32'd480);
        end
        rst = 1'b0;
        exp_q.delete();
        exp_q.push_back({12'h000, 1'b1, 1'b1});
        exp_q.push_back({12'h000, 1'b1, 1'b1});
        n_frames = 0;
    endtask

    // One abstracted frame: random pixels (biased near the logo) then the tick.
    task automatic frame(input int npix, input int fixed_bg);
        int x, y, org;
        logic [11:0] bg;
        org = model_org(n_frames);
        for (int i = 0; i < npix; i++) begin
            if ($urandom_range(0, 1)) x = $urandom_range(185, 455);
            else                      x = $urandom_range(0, 799);
            if ($urandom_range(0, 1)) begin
                y = $urandom_range((org > 5) ? org - 5 : 0, org + 105);
                if (y > 511) y = 511;
            end else begin
                y = $urandom_range(0, 511);
            end
            if (x == 0 && y == 480) x = 1;
            bg = (fixed_bg >= 0) ? 12'(fixed_bg) : 12'($urandom);
            step(x, y, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), bg, 1'b0);
        end
        step(0, 480, 1'b1, 1'b0, 12'h000, 1'b0);
    endtask

    task automatic flush();
        for (int i = 0; i < 3; i++) step(700, 500, 1'b1, 1'b1, 12'h000, 1'b0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        bus.pix_x = '0; bus.pix_y = '0; bus.video_on_in = 1'b0;
        bus.hsync_in = 1'b1; bus.vsync_in = 1'b1; bus.bg_clr = '0; bus.restart = 1'b0;
        do_reset();

        // Frame 0: origin off-screen, only background or blank.
        frame(60, 12'h00F);

        // Slide to frame 30 (origin 360), then probe the logo corners.
        for (int f = 1; f < 30; f++) frame(30, -1);
        step(195, 360, 1'b1, 1'b1, 12'h111, 1'b0);
        step(444, 459, 1'b1, 1'b1, 12'h222, 1'b0);
        step(445, 360, 1'b1, 1'b1, 12'h333, 1'b0);
        step(194, 360, 1'b1, 1'b1, 12'h444, 1'b0);
        step(195, 359, 1'b1, 1'b1, 12'h555, 1'b0);
        step(444, 460, 1'b1, 1'b1, 12'h666, 1'b0);

        // Through the clamp at frame 95 and a few held frames.
        while (n_frames < 100) frame(20, -1);

        // Constant ROM colour with an hsync edge 10 steps in.
        flush();
        rom_const_en = 1'b1; rom_const_val = 12'hABC;
        for (int i = 0; i < 20; i++) step(200 + i, 110, (i < 10), 1'b1, 12'h0AA, 1'b0);

        // Key-coloured logo pixels over a known background.
        flush();
        rom_const_val = 12'h0F0;
        for (int i = 0; i < 8; i++) step(300 + i, 150, 1'b1, 1'b1, 12'h123, 1'b0);
        flush();
        rom_const_en = 1'b0;

        // Restart coincident with a frame tick while holding.
        step(0, 480, 1'b1, 1'b0, 12'h000, 1'b1);
        for (int f = 0; f < 5; f++) frame(20, -1);

        // Restart mid-slide, then reset mid-frame.
        step(320, 240, 1'b1, 1'b1, 12'h0C3, 1'b1);
        for (int f = 0; f < 3; f++) frame(20, -1);
        for (int i = 0; i < 10; i++) step($urandom_range(0, 639), $urandom_range(0, 479), 1'b1, 1'b1, 12'($urandom), 1'b0);
        do_reset();
        for (int f = 0; f < 5; f++) frame(25, -1);
        flush();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Absolute time bound in case a stimulus step never returns.
    initial begin
        #2000000;
        errors++;
        $display("FAIL timeout: observed no completion expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
